// File: rtl/ether_pkg.sv
// rtl/ether_pkg.sv - shared Ethernet/IP stack types: IP header layout and TX arbiter state encoding
package ether_pkg;

    // Packed IP TX header {dest_ip, source_ip, protocol, ttl, length, ecn, dscp}
    localparam int IP_HDR_WIDTH        = 104;
    localparam int IP_HDR_DSCP_LSB     = 0;
    localparam int IP_HDR_ECN_LSB      = 6;
    localparam int IP_HDR_LENGTH_LSB   = 8;
    localparam int IP_HDR_TTL_LSB      = 24;
    localparam int IP_HDR_PROTOCOL_LSB = 32;
    localparam int IP_HDR_SRC_IP_LSB   = 40;
    localparam int IP_HDR_DEST_IP_LSB  = 72;

    typedef enum logic [1:0] {
        ARB_IDLE    = 2'd0,
        ARB_HDR     = 2'd1,
        ARB_PAYLOAD = 2'd2,
        ARB_DRAIN   = 2'd3
    } arb_state_t;

    function automatic logic [IP_HDR_WIDTH-1:0] ip_hdr_pack(
        input logic [31:0] dest_ip,
        input logic [31:0] source_ip,
        input logic [7:0]  protocol,
        input logic [7:0]  ttl,
        input logic [15:0] length,
        input logic [1:0]  ecn,
        input logic [5:0]  dscp
    );
        logic [IP_HDR_WIDTH-1:0] h;
        h = '0;
        h[IP_HDR_DEST_IP_LSB  +: 32] = dest_ip;
        h[IP_HDR_SRC_IP_LSB   +: 32] = source_ip;
        h[IP_HDR_PROTOCOL_LSB +: 8]  = protocol;
        h[IP_HDR_TTL_LSB      +: 8]  = ttl;
        h[IP_HDR_LENGTH_LSB   +: 16] = length;
        h[IP_HDR_ECN_LSB      +: 2]  = ecn;
        h[IP_HDR_DSCP_LSB     +: 6]  = dscp;
        return h;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin picker
// Ports: req (request vector), last_grant (index of previous winner),
//        grant (one-hot winner, 0 when no request), grant_idx (winner index).
// Search order is last_grant+1 .. last_grant+PORTS, modulo PORTS.
module rr_arbiter #(
    parameter int PORTS = 2,
    parameter int IW    = (PORTS > 1) ? $clog2(PORTS) : 1
) (
    input  logic [PORTS-1:0] req,
    input  logic [IW-1:0]    last_grant,
    output logic [PORTS-1:0] grant,
    output logic [IW-1:0]    grant_idx
);

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        // Walk downwards so the lowest offset after last_grant is written last and wins.
        for (int off = PORTS; off >= 1; off--) begin
            if (req[(int'(last_grant) + off) % PORTS]) begin
                grant                                    = '0;
                grant[(int'(last_grant) + off) % PORTS]  = 1'b1;
                grant_idx = IW'((int'(last_grant) + off) % PORTS);
            end
        end
    end

endmodule

// File: rtl/ip_tx_arbiter.sv
// rtl/ip_tx_arbiter.sv - round-robin sharing of the IP TX header/payload interface between PORTS requesters
// Ports: clk, rst (sync active-high); s_hdr_* / s_payload_* per-requester inputs (packed per port);
//        m_hdr_* / m_payload_* towards the stack; grant (one-hot owner), busy (not IDLE).
// Optional watchdog build macro: IP_TX_ARB_WATCHDOG_EN (adds WDOG_CYCLES parameter, DRAIN state, wdog_fired port).
module ip_tx_arbiter
    import ether_pkg::*;
#(
    parameter int PORTS      = 2,
    parameter int DATA_WIDTH = 8,
    parameter int HDR_WIDTH  = IP_HDR_WIDTH
`ifdef IP_TX_ARB_WATCHDOG_EN
    ,
    parameter int WDOG_CYCLES = 1024
`endif
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [PORTS-1:0]            s_hdr_valid,
    output logic [PORTS-1:0]            s_hdr_ready,
    input  logic [PORTS*HDR_WIDTH-1:0]  s_hdr,
    input  logic [PORTS*DATA_WIDTH-1:0] s_payload_tdata,
    input  logic [PORTS-1:0]            s_payload_tvalid,
    output logic [PORTS-1:0]            s_payload_tready,
    input  logic [PORTS-1:0]            s_payload_tlast,
    output logic                        m_hdr_valid,
    input  logic                        m_hdr_ready,
    output logic [HDR_WIDTH-1:0]        m_hdr,
    output logic [DATA_WIDTH-1:0]       m_payload_tdata,
    output logic                        m_payload_tvalid,
    input  logic                        m_payload_tready,
    output logic                        m_payload_tlast,
    output logic                        m_payload_tuser,
    output logic [PORTS-1:0]            grant,
    output logic                        busy
`ifdef IP_TX_ARB_WATCHDOG_EN
    ,
    output logic                        wdog_fired
`endif
);

    localparam int IW = (PORTS > 1) ? $clog2(PORTS) : 1;

    arb_state_t       state;
    logic [IW-1:0]    gidx;
    logic [IW-1:0]    last_grant;
    logic [PORTS-1:0] arb_grant;
    logic [IW-1:0]    arb_idx;

    logic                  own_tvalid;
    logic                  own_tlast;
    logic [DATA_WIDTH-1:0] own_tdata;

`ifdef IP_TX_ARB_WATCHDOG_EN
    logic [15:0] wdog_cnt;
    logic        wdog_abort;   // abort beat pending on the stack side
`endif

    rr_arbiter #(.PORTS(PORTS), .IW(IW)) u_rr (
        .req        (s_hdr_valid),
        .last_grant (last_grant),
        .grant      (arb_grant),
        .grant_idx  (arb_idx)
    );

    assign own_tvalid = s_payload_tvalid[gidx];
    assign own_tlast  = s_payload_tlast[gidx];
    assign own_tdata  = s_payload_tdata[gidx*DATA_WIDTH +: DATA_WIDTH];
    assign busy       = (state != ARB_IDLE);

    always_comb begin
        s_hdr_ready      = '0;
        s_payload_tready = '0;
        m_payload_tvalid = 1'b0;
        m_payload_tdata  = '0;
        m_payload_tlast  = 1'b0;
        m_payload_tuser  = 1'b0;
        case (state)
            ARB_IDLE: s_hdr_ready = arb_grant;
            ARB_PAYLOAD: begin
`ifdef IP_TX_ARB_WATCHDOG_EN
                if (wdog_abort) begin
                    // Synthetic terminating beat; the stalled owner is not consumed.
                    m_payload_tvalid = 1'b1;
                    m_payload_tlast  = 1'b1;
                    m_payload_tuser  = 1'b1;
                end else
`endif
                begin
                    m_payload_tvalid       = own_tvalid;
                    m_payload_tdata        = own_tdata;
                    m_payload_tlast        = own_tlast;
                    s_payload_tready[gidx] = m_payload_tready;
                end
            end
`ifdef IP_TX_ARB_WATCHDOG_EN
            ARB_DRAIN: s_payload_tready[gidx] = 1'b1;
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ARB_IDLE;
            grant       <= '0;
            gidx        <= '0;
            last_grant  <= IW'(PORTS - 1);
            m_hdr       <= '0;
            m_hdr_valid <= 1'b0;
`ifdef IP_TX_ARB_WATCHDOG_EN
            wdog_cnt    <= '0;
            wdog_abort  <= 1'b0;
            wdog_fired  <= 1'b0;
`endif
        end else begin
`ifdef IP_TX_ARB_WATCHDOG_EN
            wdog_fired <= 1'b0;
`endif
            case (state)
                ARB_IDLE: begin
                    if (|s_hdr_valid) begin
                        m_hdr       <= s_hdr[arb_idx*HDR_WIDTH +: HDR_WIDTH];
                        grant       <= arb_grant;
                        gidx        <= arb_idx;
                        m_hdr_valid <= 1'b1;
                        state       <= ARB_HDR;
                    end
                end
                ARB_HDR: begin
                    if (m_hdr_ready) begin
                        m_hdr_valid <= 1'b0;
                        state       <= ARB_PAYLOAD;
`ifdef IP_TX_ARB_WATCHDOG_EN
                        wdog_cnt    <= '0;
`endif
                    end
                end
                ARB_PAYLOAD: begin
`ifdef IP_TX_ARB_WATCHDOG_EN
                    if (wdog_abort) begin
                        if (m_payload_tready) begin
                            wdog_abort <= 1'b0;
                            state      <= ARB_DRAIN;
                        end
                    end else
`endif
                    if (own_tvalid && m_payload_tready) begin
`ifdef IP_TX_ARB_WATCHDOG_EN
                        wdog_cnt <= '0;
`endif
                        if (own_tlast) begin
                            last_grant <= gidx;
                            grant      <= '0;
                            state      <= ARB_IDLE;
                        end
                    end
`ifdef IP_TX_ARB_WATCHDOG_EN
                    else if (!own_tvalid) begin
                        // Count owner starvation only; stack back-pressure is not a stall.
                        wdog_cnt <= wdog_cnt + 16'd1;
                        if (wdog_cnt == 16'(WDOG_CYCLES - 1)) begin
                            wdog_abort <= 1'b1;
                            wdog_fired <= 1'b1;
                        end
                    end
`endif
                end
`ifdef IP_TX_ARB_WATCHDOG_EN
                ARB_DRAIN: begin
                    if (own_tvalid && own_tlast) begin
                        last_grant <= gidx;
                        grant      <= '0;
                        wdog_cnt   <= '0;
                        state      <= ARB_IDLE;
                    end
                end
`endif
                default: state <= ARB_IDLE;
            endcase
        end
    end

endmodule
